// File: rtl/y86_mem_pkg.sv
// y86_mem_pkg: shared state, error codes and word size for the Y86-64 data memory
package y86_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] DMEM_OK = 2'd0;
  localparam logic [1:0] DMEM_RANGE = 2'd1;
  localparam logic [1:0] DMEM_ALIGN = 2'd2;
  localparam int WORD_BYTES = 8;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous 64-bit RAM with strobed registered read
module dmem_array #(
  parameter int DEPTH = 8192,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/y86_dmem_ctrl.sv
// y86_dmem_ctrl: latency-configurable data-memory controller with range/alignment errors
module y86_dmem_ctrl
  import y86_mem_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int LATENCY = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [1:0]  resp_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic cap_write, zero, accept, wait_done, we, re;
  logic [1:0] cap_err, err;
  logic [AW-1:0] cap_idx, idx;
  logic [63:0] arr_rdata;
  always_comb begin
    accept = req_valid && req_ready && !rst;
    err = req_addr >= 64'(DEPTH * WORD_BYTES) ? DMEM_RANGE :
          (ALIGN_CHECK != 0 && req_addr[2:0] != 3'd0) ? DMEM_ALIGN : DMEM_OK;
    wait_done = state == WAIT && cnt == '0;
    we = accept && req_write && err == DMEM_OK;
    re = (accept && LATENCY == 1 && !req_write && err == DMEM_OK) ||
         (wait_done && !cap_write && cap_err == DMEM_OK);
    // In WAIT no request can be accepted, so the port is free for the delayed read
    idx = wait_done ? cap_idx : req_addr[AW+2:3];
  end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(we),
    .re(re),
    .addr(idx),
    .wdata(req_wdata),
    .rdata(arr_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= DMEM_OK;
      zero <= 1'b1;
    end else begin
      if (accept) begin
        cap_write <= req_write;
        cap_err <= err;
        cap_idx <= req_addr[AW+2:3];
      end
      if (accept && LATENCY == 1) begin
        state <= RESP;
        req_ready <= 1'b1;
        resp_valid <= 1'b1;
        resp_error <= err;
        zero <= req_write || err != DMEM_OK;
      end else if (accept) begin
        state <= WAIT;
        cnt <= CW'(LATENCY > 1 ? LATENCY - 2 : 0);
        req_ready <= 1'b0;
        resp_valid <= 1'b0;
      end else if (wait_done) begin
        state <= RESP;
        req_ready <= 1'b1;
        resp_valid <= 1'b1;
        resp_error <= cap_err;
        zero <= cap_write || cap_err != DMEM_OK;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end else begin
        state <= IDLE;
        req_ready <= 1'b1;
        resp_valid <= 1'b0;
      end
    end
  end
  assign resp_rdata = zero ? '0 : arr_rdata;
endmodule

// File: doc/y86_dmem_ctrl.md
# y86_dmem_ctrl

Parametrised data-memory block for the Y86-64 SEQ/PIPE datapaths, used in the memory stage. It accepts one read or write request at a time over a valid/ready handshake and returns a response after a configurable number of wait cycles. Address range and alignment are checked, and an error code is returned instead of silently accessing memory. A non-zero `LATENCY` lets the pipeline exercise stall logic against a slow memory.

## Interface
Parameters:
- `DEPTH`, default 8192: number of 64-bit words; must be a power of two.
- `LATENCY`, default 1: cycles from request acceptance to `resp_valid`; must be ≥1.
- `ALIGN_CHECK`, default 1: 1 flags any address with `addr[2:0]!=0`; 0 ignores the low 3 bits.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: block can accept a request this cycle.
- `req_write`, input, 1: 1 = write (rmmovq/call/pushq), 0 = read (mrmovq/ret/popq).
- `req_addr`, input, 64: byte address (valE or valA, selected upstream).
- `req_wdata`, input, 64: write data.
- `resp_valid`, output, 1: one-cycle response pulse.
- `resp_rdata`, output, 64: read data; 0 for writes and for errored reads.
- `resp_error`, output, 2: 0 = OK, 1 = out of range, 2 = misaligned.

## Operation
- Word index is `req_addr[3+$clog2(DEPTH)-1:3]`.
- Out of range means `req_addr >= DEPTH*8`. This check takes priority over misalignment.
- A request is accepted on a rising edge where `req_valid && req_ready`.
- Write accepted with no error: the array is updated on the acceptance edge.
- Errored write: the array is not modified.
- Read: data is sampled from the array on the edge that enters RESP and held in `resp_rdata` during the RESP cycle.
- State machine states are IDLE, WAIT and RESP.
  - IDLE: `req_ready=1`. On accept, go to RESP if `LATENCY==1`, otherwise go to WAIT with the counter loaded to `LATENCY-2`.
  - WAIT: `req_ready=0`. The counter decrements each cycle; when the counter is 0, go to RESP.
  - RESP: `resp_valid=1` and `req_ready=1`. On accept in this cycle, follow the same transition as from IDLE; otherwise go to IDLE.
- Only one request is outstanding at a time. Request fields are captured on acceptance, so the upstream may change them afterwards.
- Reset values:
  - state = IDLE, counter = 0.
  - `req_ready=1` from the first cycle after reset.
  - `resp_valid=0`, `resp_rdata=0`, `resp_error=0`.
  - Array contents are not reset.
- Reset during WAIT or RESP: the outstanding response is dropped and no `resp_valid` is produced. A write committed at acceptance stays committed.
- `req_valid` asserted in the same cycle as `rst`: the request is ignored.

## Timing
- Acceptance at edge k: `resp_valid` is high in the cycle following edge k+LATENCY-1 and is low again after edge k+LATENCY.
- `LATENCY=1`: back-to-back requests give one response per cycle. Throughput is 1 per `LATENCY` cycles in general.
- Read-after-write to the same address, accepted on consecutive handshakes, returns the new data. Writes commit before any later read samples the array.
- `req_ready` is a pure function of state, with no combinational path from `req_valid`.
- `resp_error` and `resp_rdata` are valid only while `resp_valid=1`; they hold their last value otherwise.

## Structure
- Package `y86_mem_pkg` holds:
  - the state enum (IDLE, WAIT, RESP);
  - error code constants `DMEM_OK=2'd0`, `DMEM_RANGE=2'd1`, `DMEM_ALIGN=2'd2`;
  - `WORD_BYTES=8`.
- Sub-module `dmem_array` is a single-port synchronous RAM with parameter `DEPTH`, a 64-bit word, write enable, and read data registered on a read-enable strobe.
- The controller (FSM, counter, error decode, response registers) lives in `y86_dmem_ctrl`.

## Test plan
- `LATENCY=1`: write 0xDEADBEEF_CAFEF00D to 0x100, then read 0x100 on the next cycle. Required: the second response is rdata=0xDEADBEEF_CAFEF00D with error=0, on consecutive `resp_valid` cycles.
- `LATENCY=3`: read 0x0 accepted at edge k. Required: `req_ready=0` for two cycles, `resp_valid` only in the cycle after edge k+2, `req_ready=1` in that same cycle.
- `DEPTH=8192`: write to 0x10000, then read 0x10000. Required: error=1 on both responses, rdata=0, and word 0 is unchanged.
- `ALIGN_CHECK=1`: read 0x104. Required: error=2, rdata=0. With `ALIGN_CHECK=0`, the same read returns word 0x100.
- `LATENCY=4`: assert `rst` during WAIT. Required: no `resp_valid` is produced, outputs go to 0, `req_ready=1` from the next cycle, and a subsequent read returns data from the earlier committed write.
